// File: rtl/bufdiv_seq_pkg.sv
// Shared types and default timing for the BUFGCE_DIV alignment sequencer.
// The helper sizes counters from whichever timing parameter is largest.
package bufdiv_seq_pkg;

   typedef enum logic [3:0] {
      S_WAIT_LOCK,
      S_DEBOUNCE,
      S_CE_OFF,
      S_CLR_ON,
      S_CE_LAG,
      S_SETTLE,
      S_RUN,
      S_MMCM_RST,
      S_FAULT
   } state_t;

   localparam int DEF_LOCK_STABLE = 64;
   localparam int DEF_CE_LEAD     = 2;
   localparam int DEF_CLR_WIDTH   = 1;
   localparam int DEF_CE_LAG      = 2;
   localparam int DEF_SETTLE      = 16;
   localparam int DEF_TIMEOUT     = 4096;
   localparam int DEF_RST_WIDTH   = 16;
   localparam int DEF_MAX_RETRY   = 3;

   localparam int CNT_W = $clog2(DEF_TIMEOUT) + 1;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/bufdiv_align_sequencer_sync_2ff.sv
// Two-flop synchroniser for the asynchronous MMCM/CDCM lock input.
// Resets to 0 so the sequencer always starts from "not locked".
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   (* ASYNC_REG = "TRUE" *) logic r_meta;
   (* ASYNC_REG = "TRUE" *) logic r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/bufdiv_align_sequencer.sv
// Debounces MMCM lock, drives the BUFGCE_DIV CE-low / CLR / CE-high alignment sequence,
// and resets the MMCM with bounded retries when lock never settles.
module bufdiv_align_sequencer
   import bufdiv_seq_pkg::*;
#(
   parameter int LOCK_STABLE = DEF_LOCK_STABLE,
   parameter int CE_LEAD     = DEF_CE_LEAD,
   parameter int CLR_WIDTH   = DEF_CLR_WIDTH,
   parameter int CE_LAG      = DEF_CE_LAG,
   parameter int SETTLE      = DEF_SETTLE,
   parameter int TIMEOUT     = DEF_TIMEOUT,
   parameter int RST_WIDTH   = DEF_RST_WIDTH,
   parameter int MAX_RETRY   = DEF_MAX_RETRY
) (
   input  logic       clk_CLR,
   input  logic       rst_n,
   input  logic       mmcm_cdcm_locked,
   input  logic       realign_req,
   output logic       BUFDIV_CE,
   output logic       BUFDIV_CLR,
   output logic       mmcm_cdcm_locked_level2,
   output logic       mmcm_reset,
   output logic       busy,
   output logic       fault,
   output logic [7:0] align_count
);

   localparam int CNT_MAX = max_int(max_int(max_int(LOCK_STABLE, TIMEOUT),
                                            max_int(CE_LEAD, CLR_WIDTH)),
                                    max_int(max_int(CE_LAG, SETTLE), RST_WIDTH));
   localparam int W  = $clog2(CNT_MAX) + 1;
   localparam int RW = $clog2(MAX_RETRY + 1) + 1;

   state_t        r_state;
   state_t        w_next;
   state_t        w_tmo_dest;
   logic [W-1:0]  r_cnt;
   logic [W-1:0]  r_tmo;
   logic [RW-1:0] r_retry;
   logic [7:0]    r_align;
   logic          r_ce;
   logic          r_clr;
   logic          r_ready;
   logic          r_mrst;
   logic          r_busy;
   logic          r_fault;
   logic          w_lk;
   logic          w_in_wait;
   logic          w_next_wait;
   logic          w_tmo_hit;
   logic          w_timed;

   sync_2ff u_sync (
      .clk   (clk_CLR),
      .rst_n (rst_n),
      .i_d   (mmcm_cdcm_locked),
      .o_q   (w_lk)
   );

   assign w_in_wait   = (r_state == S_WAIT_LOCK) || (r_state == S_DEBOUNCE);
   assign w_next_wait = (w_next == S_WAIT_LOCK) || (w_next == S_DEBOUNCE);
   assign w_tmo_hit   = w_in_wait && (r_tmo == W'(TIMEOUT - 1));
   assign w_tmo_dest  = (r_retry < RW'(MAX_RETRY)) ? S_MMCM_RST : S_FAULT;
   assign w_timed     = (r_state == S_DEBOUNCE) || (r_state == S_CE_OFF) ||
                        (r_state == S_CLR_ON)   || (r_state == S_CE_LAG) ||
                        (r_state == S_SETTLE)   || (r_state == S_MMCM_RST);

   // Lock loss is tested first in every aligning state so it beats realign and counter expiry.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_WAIT_LOCK: begin
            if (w_tmo_hit)  w_next = w_tmo_dest;
            else if (w_lk)  w_next = S_DEBOUNCE;
         end
         S_DEBOUNCE: begin
            if (w_tmo_hit)                               w_next = w_tmo_dest;
            else if (!w_lk)                              w_next = S_WAIT_LOCK;
            else if (r_cnt == W'(LOCK_STABLE - 1))       w_next = S_CE_OFF;
         end
         S_CE_OFF: begin
            if (!w_lk)                                   w_next = S_WAIT_LOCK;
            else if (r_cnt == W'(CE_LEAD - 1))           w_next = S_CLR_ON;
         end
         S_CLR_ON: begin
            if (!w_lk)                                   w_next = S_WAIT_LOCK;
            else if (r_cnt == W'(CLR_WIDTH - 1))         w_next = S_CE_LAG;
         end
         S_CE_LAG: begin
            if (!w_lk)                                   w_next = S_WAIT_LOCK;
            else if (r_cnt == W'(CE_LAG - 1))            w_next = S_SETTLE;
         end
         S_SETTLE: begin
            if (!w_lk)                                   w_next = S_WAIT_LOCK;
            else if (r_cnt == W'(SETTLE - 1))            w_next = S_RUN;
         end
         S_RUN: begin
            if (!w_lk)                                   w_next = S_WAIT_LOCK;
            else if (realign_req)                        w_next = S_CE_OFF;
         end
         S_MMCM_RST: begin
            if (r_cnt == W'(RST_WIDTH - 1))              w_next = S_WAIT_LOCK;
         end
         S_FAULT:     w_next = S_FAULT;
         default:     w_next = S_WAIT_LOCK;
      endcase
   end

   always_ff @(posedge clk_CLR or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_WAIT_LOCK;
         r_cnt   <= '0;
         r_tmo   <= '0;
         r_retry <= '0;
         r_align <= '0;
         r_ce    <= 1'b0;
         r_clr   <= 1'b0;
         r_ready <= 1'b0;
         r_mrst  <= 1'b0;
         r_busy  <= 1'b1;
         r_fault <= 1'b0;
      end else begin
         r_state <= w_next;

         if (w_next != r_state)  r_cnt <= '0;
         else if (w_timed)       r_cnt <= r_cnt + W'(1);

         // Timeout spans WAIT_LOCK and DEBOUNCE together, so a debounce glitch does not restart it.
         if (w_next_wait && w_in_wait) r_tmo <= r_tmo + W'(1);
         else                          r_tmo <= '0;

         if (w_next == S_MMCM_RST && r_state != S_MMCM_RST)  r_retry <= r_retry + RW'(1);
         else if (w_next == S_RUN && r_state != S_RUN)       r_retry <= '0;

         if (w_next == S_RUN && r_state != S_RUN && r_align != 8'hFF)
            r_align <= r_align + 8'd1;

         // Pin outputs are decoded from the current state, one cycle behind the state change.
         r_ce    <= (r_state == S_SETTLE) || (r_state == S_RUN);
         r_clr   <= (r_state == S_CLR_ON);
         r_ready <= (r_state == S_RUN);
         r_mrst  <= (r_state == S_MMCM_RST);
         r_busy  <= (r_state != S_RUN) && (r_state != S_FAULT);
         r_fault <= (r_state == S_FAULT);
      end
   end

   assign BUFDIV_CE               = r_ce;
   assign BUFDIV_CLR              = r_clr;
   assign mmcm_cdcm_locked_level2 = r_ready;
   assign mmcm_reset              = r_mrst;
   assign busy                    = r_busy;
   assign fault                   = r_fault;
   assign align_count             = r_align;

endmodule

// File: tb/tb_bufdiv_align_sequencer.sv
// Scoreboard bench: expected output edges (signal, value, cycle) are queued as stimulus is
// applied; a negedge monitor pops one entry per observed edge and compares.
module tb_bufdiv_align_sequencer;

   localparam int LS   = 64;
   localparam int LEAD = 2;
   localparam int CLRW = 1;
   localparam int LAG  = 2;
   localparam int SETL = 16;
   localparam int TO   = 4096;
   localparam int RSTW = 16;
   localparam int MAXR = 3;

   localparam int SIG_CE = 0, SIG_CLR = 1, SIG_RDY = 2, SIG_MRST = 3, SIG_FLT = 4;

   logic       clk_CLR;
   logic       rst_n;
   logic       lock;
   logic       req;
   logic       ce, clr, rdy, mrst, bsy, flt;
   logic [7:0] acnt;

   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   bit          mon_en = 0;
   logic [4:0]  prev = '0;
   logic [63:0] exp_q[$];

   bufdiv_align_sequencer #(
      .LOCK_STABLE (LS),   .CE_LEAD (LEAD), .CLR_WIDTH (CLRW), .CE_LAG (LAG),
      .SETTLE      (SETL), .TIMEOUT (TO),   .RST_WIDTH (RSTW), .MAX_RETRY (MAXR)
   ) dut (
      .clk_CLR                 (clk_CLR),
      .rst_n                   (rst_n),
      .mmcm_cdcm_locked        (lock),
      .realign_req             (req),
      .BUFDIV_CE               (ce),
      .BUFDIV_CLR              (clr),
      .mmcm_cdcm_locked_level2 (rdy),
      .mmcm_reset              (mrst),
      .busy                    (bsy),
      .fault                   (flt),
      .align_count             (acnt)
   );

   initial begin
      clk_CLR = 1'b0;
      forever #5 clk_CLR = ~clk_CLR;
   end

   always @(posedge clk_CLR) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [63:0] ev(input int sig, input logic val, input int c);
      logic [2:0] s;
      s = sig[2:0];
      return {28'd0, s, val, c[31:0]};
   endfunction

   task automatic push(input int sig, input logic val, input int c);
      exp_q.push_back(ev(sig, val, c));
   endtask

   // Ready cycle for a sequence whose CE_OFF state is entered at posedge s.
   function automatic int ready_at(input int s);
      return s + LEAD + 1 + CLRW + LAG + SETL;
   endfunction

   task automatic push_align(input int s);
      push(SIG_CLR, 1'b1, s + LEAD + 1);
      push(SIG_CLR, 1'b0, s + LEAD + 1 + CLRW);
      push(SIG_CE,  1'b1, s + LEAD + 1 + CLRW + LAG);
      push(SIG_RDY, 1'b1, ready_at(s));
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk_CLR);
         #1;
      end
   endtask

   task automatic goto(input int c);
      while (cyc < c) step(1);
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_ce"},    64'(ce),   64'd0);
      check_eq({tag, "_clr"},   64'(clr),  64'd0);
      check_eq({tag, "_ready"}, 64'(rdy),  64'd0);
      check_eq({tag, "_mrst"},  64'(mrst), 64'd0);
      check_eq({tag, "_busy"},  64'(bsy),  64'd1);
      check_eq({tag, "_fault"}, 64'(flt),  64'd0);
      check_eq({tag, "_count"}, 64'(acnt), 64'd0);
   endtask

   always @(negedge clk_CLR) begin
      logic [4:0]  cur;
      logic [63:0] obs;
      logic [63:0] expv;
      cur = {flt, mrst, rdy, clr, ce};
      check_eq("ce_clr_exclusive", 64'(ce & clr), 64'd0);
      if (mon_en) begin
         for (int s = 0; s < 5; s++) begin
            if (cur[s] !== prev[s]) begin
               obs  = ev(s, cur[s], cyc);
               expv = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
               $display("edge sig=%0d val=%0b cycle=%0d", s, cur[s], cyc);
               check_eq("edge", obs, expv);
            end
         end
      end
      prev = cur;
   end

   initial begin
      int t;
      int w;
      rst_n = 1'b0;
      lock  = 1'b0;
      req   = 1'b0;
      step(3);
      check_reset_vals("reset");
      rst_n  = 1'b1;
      mon_en = 1;
      step(5);

      // Lock rises and stays: full sequence at fixed offsets.
      t = cyc;
      lock = 1'b1;
      push_align(t + 3 + LS);
      goto(ready_at(t + 3 + LS) + 5);
      check_eq("s1_queue_empty", 64'(exp_q.size()), 64'd0);
      check_eq("s1_count", 64'(acnt), 64'd1);
      check_eq("s1_ready", 64'(rdy),  64'd1);
      check_eq("s1_busy",  64'(bsy),  64'd0);

      // Realign from RUN; second request during SETTLE is dropped.
      t = cyc;
      req = 1'b1;
      push(SIG_CE,  1'b0, t + 2);
      push(SIG_RDY, 1'b0, t + 2);
      push_align(t + 1);
      step(1);
      req = 1'b0;
      goto(t + 10);
      req = 1'b1;
      step(1);
      req = 1'b0;
      goto(ready_at(t + 1) + 5);
      check_eq("s3_queue_empty", 64'(exp_q.size()), 64'd0);
      check_eq("s3_count", 64'(acnt), 64'd2);

      // Lock loss from RUN, then a glitch in the middle of debounce.
      t = cyc;
      lock = 1'b0;
      push(SIG_CE,  1'b0, t + 4);
      push(SIG_RDY, 1'b0, t + 4);
      goto(t + 10);
      check_eq("s2_busy_after_loss", 64'(bsy), 64'd1);
      t = cyc;
      lock = 1'b1;
      goto(t + 30);
      lock = 1'b0;
      step(1);
      lock = 1'b1;
      push_align(t + 31 + 3 + LS);
      goto(ready_at(t + 31 + 3 + LS) + 5);
      check_eq("s2_queue_empty", 64'(exp_q.size()), 64'd0);
      check_eq("s2_count", 64'(acnt), 64'd3);

      // Lock drops during CLR_ON together with a realign request.
      t = cyc;
      req = 1'b1;
      push(SIG_CE,  1'b0, t + 2);
      push(SIG_RDY, 1'b0, t + 2);
      push(SIG_CLR, 1'b1, t + 4);
      push(SIG_CLR, 1'b0, t + 5);
      step(1);
      req  = 1'b0;
      lock = 1'b0;
      goto(t + 3);
      req = 1'b1;
      step(1);
      req = 1'b0;
      goto(t + 40);
      check_eq("s5_queue_empty", 64'(exp_q.size()), 64'd0);
      check_eq("s5_ce_low",   64'(ce),   64'd0);
      check_eq("s5_busy",     64'(bsy),  64'd1);
      check_eq("s5_count",    64'(acnt), 64'd3);
      t = cyc;
      lock = 1'b1;
      push_align(t + 3 + LS);
      goto(ready_at(t + 3 + LS) + 5);
      check_eq("s5_rerun_queue_empty", 64'(exp_q.size()), 64'd0);
      check_eq("s5_rerun_count", 64'(acnt), 64'd4);

      // Asynchronous reset during CE_LAG, then a clean sequence.
      t = cyc;
      req = 1'b1;
      push(SIG_CE,  1'b0, t + 2);
      push(SIG_RDY, 1'b0, t + 2);
      push(SIG_CLR, 1'b1, t + 4);
      push(SIG_CLR, 1'b0, t + 5);
      step(1);
      req = 1'b0;
      goto(t + 5);
      mon_en = 0;
      check_eq("s6_pre_reset_queue", 64'(exp_q.size()), 64'd0);
      rst_n = 1'b0;
      #1;
      check_reset_vals("s6_async");
      step(4);
      check_eq("s6_held_count", 64'(acnt), 64'd0);
      rst_n  = 1'b1;
      mon_en = 1;
      t = cyc;
      push_align(t + 3 + LS);
      goto(ready_at(t + 3 + LS) + 5);
      check_eq("s6_queue_empty", 64'(exp_q.size()), 64'd0);
      check_eq("s6_count", 64'(acnt), 64'd1);
      check_eq("s6_ready", 64'(rdy),  64'd1);

      // Lock never returns: three MMCM reset pulses, then sticky fault.
      t = cyc;
      lock = 1'b0;
      push(SIG_CE,  1'b0, t + 4);
      push(SIG_RDY, 1'b0, t + 4);
      w = t + 3;
      for (int i = 0; i < MAXR; i++) begin
         push(SIG_MRST, 1'b1, w + TO + 1);
         push(SIG_MRST, 1'b0, w + TO + 1 + RSTW);
         w = w + TO + RSTW;
      end
      push(SIG_FLT, 1'b1, w + TO + 1);
      goto(w + TO + 10);
      check_eq("s4_queue_empty", 64'(exp_q.size()), 64'd0);
      check_eq("s4_fault", 64'(flt),  64'd1);
      check_eq("s4_ce",    64'(ce),   64'd0);
      check_eq("s4_mrst",  64'(mrst), 64'd0);
      check_eq("s4_busy",  64'(bsy),  64'd0);
      lock = 1'b1;
      step(200);
      check_eq("s4_fault_held", 64'(flt), 64'd1);
      check_eq("s4_ready_held", 64'(rdy), 64'd0);
      check_eq("s4_ce_held",    64'(ce),  64'd0);
      mon_en = 0;
      rst_n  = 1'b0;
      #1;
      check_eq("s4_fault_cleared", 64'(flt), 64'd0);
      check_eq("s4_busy_reset",    64'(bsy), 64'd1);
      step(2);
      rst_n = 1'b1;
      step(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
